// File: rtl/axi_wr_arb_pkg.sv
// axi_wr_arb_pkg: shared FSM state type, B-response codes and the index-width
// helper for the AXI write-channel arbiter (axi_wr_arb_ctrl).
package axi_wr_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      XFER = 2'b01,
      RESP = 2'b10
   } arb_state_t;

   localparam logic [1:0] BRESP_OKAY   = 2'b00;
   localparam logic [1:0] BRESP_SLVERR = 2'b10;

   // Bits needed to index n items; never less than one bit.
   function automatic int idx_w(input int n);
      if (n > 1) begin
         return $clog2(n);
      end else begin
         return 1;
      end
   endfunction

endpackage

// File: rtl/axi_wr_arb_ctrl_rr_pick.sv
// axi_rr_pick: combinational round-robin selector. Picks the first asserted
// request at or above the pointer, wrapping past the top index.
module axi_rr_pick
   import axi_wr_arb_pkg::*;
#(
   parameter int NUM_M = 4,
   parameter int IDX_W = idx_w(NUM_M)
) (
   input  logic [NUM_M-1:0] req,
   input  logic [IDX_W-1:0] ptr,
   output logic [NUM_M-1:0] gnt_oh,
   output logic [IDX_W-1:0] gnt_idx
);

   // Scan NUM_M candidates starting at the pointer; first hit wins.
   always_comb begin
      int  cand;
      logic found;
      gnt_oh  = '0;
      gnt_idx = '0;
      found   = 1'b0;
      cand    = 0;
      for (int k = 0; k < NUM_M; k++) begin
         cand = (int'(ptr) + k) % NUM_M;
         if (!found && req[cand]) begin
            gnt_oh[cand] = 1'b1;
            gnt_idx      = IDX_W'(cand);
            found        = 1'b1;
         end else begin
            found = found;
         end
      end
   end

endmodule

// File: rtl/axi_wr_arb_ctrl.sv
// axi_wr_arb_ctrl: shares one downstream AXI write port between NUM_M masters.
// A master is picked round-robin and holds the port for one full transaction
// (AW, W through WLAST, B). Optional response watchdog: AXI_WR_ARB_TIMEOUT_EN.
module axi_wr_arb_ctrl
   import axi_wr_arb_pkg::*;
#(
   parameter int NUM_M  = 4,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int ID_W   = 4
`ifdef AXI_WR_ARB_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYC = 256
`endif
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_M-1:0]           m_awvalid,
   output logic [NUM_M-1:0]           m_awready,
   input  logic [NUM_M*ADDR_W-1:0]    m_awaddr,
   input  logic [NUM_M*ID_W-1:0]      m_awid,
   input  logic [NUM_M*8-1:0]         m_awlen,
   input  logic [NUM_M-1:0]           m_wvalid,
   output logic [NUM_M-1:0]           m_wready,
   input  logic [NUM_M*DATA_W-1:0]    m_wdata,
   input  logic [NUM_M-1:0]           m_wlast,
   output logic [NUM_M-1:0]           m_bvalid,
   input  logic [NUM_M-1:0]           m_bready,
   output logic [1:0]                 m_bresp,
   output logic [ID_W-1:0]            m_bid,
   output logic                       s_awvalid,
   input  logic                       s_awready,
   output logic [ADDR_W-1:0]          s_awaddr,
   output logic [ID_W-1:0]            s_awid,
   output logic [7:0]                 s_awlen,
   output logic                       s_wvalid,
   input  logic                       s_wready,
   output logic [DATA_W-1:0]          s_wdata,
   output logic                       s_wlast,
   input  logic                       s_bvalid,
   output logic                       s_bready,
   input  logic [1:0]                 s_bresp,
   input  logic [ID_W-1:0]            s_bid,
   output logic [$clog2(NUM_M)-1:0]   grant_idx,
`ifdef AXI_WR_ARB_TIMEOUT_EN
   output logic                       timeout_err,
`endif
   output logic                       busy
);

   localparam int IDX_W = idx_w(NUM_M);

   arb_state_t       state_r, state_n;
   logic [IDX_W-1:0] grant_r, ptr_r;
   logic             aw_done_r, aw_done_n;
   logic             w_done_r, w_done_n;
   logic             busy_r;
   logic [NUM_M-1:0] pick_oh_s;
   logic [IDX_W-1:0] pick_idx_s;
   logic             pick_any_s;

`ifdef AXI_WR_ARB_TIMEOUT_EN
   localparam int CNT_W = idx_w(TIMEOUT_CYC + 1);
   logic [CNT_W-1:0] tmo_cnt_r;
   logic [ID_W-1:0]  bid_r;
   logic             timeout_err_r;
   logic             tmo_hit_s;
`endif

   axi_rr_pick #(
      .NUM_M (NUM_M),
      .IDX_W (IDX_W)
   ) u_pick (
      .req     (m_awvalid),
      .ptr     (ptr_r),
      .gnt_oh  (pick_oh_s),
      .gnt_idx (pick_idx_s)
   );

   assign pick_any_s = |pick_oh_s;
   assign grant_idx  = grant_r;
   assign busy       = busy_r;

   // Next-state logic and routing of the granted master onto the slave port.
   always_comb begin
      state_n   = state_r;
      aw_done_n = aw_done_r;
      w_done_n  = w_done_r;
      m_awready = '0;
      m_wready  = '0;
      m_bvalid  = '0;
      m_bresp   = BRESP_OKAY;
      m_bid     = s_bid;
      s_awvalid = 1'b0;
      s_wvalid  = 1'b0;
      s_bready  = 1'b0;
      s_awaddr  = m_awaddr[grant_r*ADDR_W +: ADDR_W];
      s_awid    = m_awid[grant_r*ID_W +: ID_W];
      s_awlen   = m_awlen[grant_r*8 +: 8];
      s_wdata   = m_wdata[grant_r*DATA_W +: DATA_W];
      s_wlast   = m_wlast[grant_r];
      case (state_r)
         IDLE: begin
            if (pick_any_s) begin
               state_n = XFER;
            end else begin
               state_n = IDLE;
            end
         end
         XFER: begin
            s_awvalid           = !aw_done_r && m_awvalid[grant_r];
            m_awready[grant_r]  = !aw_done_r && s_awready;
            s_wvalid            = !w_done_r && m_wvalid[grant_r];
            m_wready[grant_r]   = !w_done_r && s_wready;
            aw_done_n = aw_done_r || (s_awvalid && s_awready);
            w_done_n  = w_done_r || (s_wvalid && s_wready && s_wlast);
            if (aw_done_n && w_done_n) begin
               state_n = RESP;
            end else begin
               state_n = XFER;
            end
         end
         RESP: begin
`ifdef AXI_WR_ARB_TIMEOUT_EN
            if (tmo_hit_s) begin
               m_bvalid[grant_r] = 1'b1;
               m_bresp           = BRESP_SLVERR;
               m_bid             = bid_r;
               if (m_bready[grant_r]) begin
                  state_n   = IDLE;
                  aw_done_n = 1'b0;
                  w_done_n  = 1'b0;
               end else begin
                  state_n = RESP;
               end
            end else begin
`endif
               s_bready          = m_bready[grant_r];
               m_bvalid[grant_r] = s_bvalid;
               m_bresp           = s_bresp;
               if (s_bvalid && m_bready[grant_r]) begin
                  state_n   = IDLE;
                  aw_done_n = 1'b0;
                  w_done_n  = 1'b0;
               end else begin
                  state_n = RESP;
               end
`ifdef AXI_WR_ARB_TIMEOUT_EN
            end
`endif
         end
         default: begin
            state_n   = IDLE;
            aw_done_n = 1'b0;
            w_done_n  = 1'b0;
         end
      endcase
   end

   // State, completion flags, grant and round-robin pointer registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r   <= IDLE;
         aw_done_r <= 1'b0;
         w_done_r  <= 1'b0;
         grant_r   <= '0;
         ptr_r     <= '0;
         busy_r    <= 1'b0;
      end else begin
         state_r   <= state_n;
         aw_done_r <= aw_done_n;
         w_done_r  <= w_done_n;
         busy_r    <= (state_n != IDLE);
         if (state_r == IDLE && pick_any_s) begin
            grant_r <= pick_idx_s;
            ptr_r   <= (pick_idx_s == IDX_W'(NUM_M - 1)) ? '0 : pick_idx_s + IDX_W'(1);
         end else begin
            grant_r <= grant_r;
            ptr_r   <= ptr_r;
         end
      end
   end

`ifdef AXI_WR_ARB_TIMEOUT_EN
   assign tmo_hit_s   = (tmo_cnt_r == CNT_W'(TIMEOUT_CYC));
   assign timeout_err = timeout_err_r;

   // Response watchdog: count RESP cycles without s_bvalid, keep the AWID for the error B.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tmo_cnt_r     <= '0;
         bid_r         <= '0;
         timeout_err_r <= 1'b0;
      end else begin
         if (state_r == XFER && state_n == RESP) begin
            tmo_cnt_r <= '0;
         end else if (state_r == RESP && !s_bvalid && !tmo_hit_s) begin
            tmo_cnt_r <= tmo_cnt_r + CNT_W'(1);
         end else begin
            tmo_cnt_r <= tmo_cnt_r;
         end
         if (s_awvalid && s_awready) begin
            bid_r <= m_awid[grant_r*ID_W +: ID_W];
         end else begin
            bid_r <= bid_r;
         end
         timeout_err_r <= (state_r == RESP) && tmo_hit_s && m_bready[grant_r];
      end
   end
`endif

endmodule

// File: tb/tb_axi_wr_arb_ctrl.sv
// tb_axi_wr_arb_ctrl: directed self-checking bench for axi_wr_arb_ctrl.
// Build with +define+AXI_WR_ARB_TIMEOUT_EN to add the watchdog scenario.
module tb_axi_wr_arb_ctrl;

   localparam int NUM_M  = 4;
   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int ID_W   = 4;

   logic                    clk = 1'b0;
   logic                    rst;
   logic [NUM_M-1:0]        m_awvalid, m_awready, m_wvalid, m_wready, m_wlast, m_bvalid, m_bready;
   logic [NUM_M*ADDR_W-1:0] m_awaddr;
   logic [NUM_M*ID_W-1:0]   m_awid;
   logic [NUM_M*8-1:0]      m_awlen;
   logic [NUM_M*DATA_W-1:0] m_wdata;
   logic [1:0]              m_bresp, s_bresp;
   logic [ID_W-1:0]         m_bid, s_awid, s_bid;
   logic                    s_awvalid, s_awready, s_wvalid, s_wready, s_wlast, s_bvalid, s_bready;
   logic [ADDR_W-1:0]       s_awaddr;
   logic [7:0]              s_awlen;
   logic [DATA_W-1:0]       s_wdata;
   logic [1:0]              grant_idx;
   logic                    busy;
`ifdef AXI_WR_ARB_TIMEOUT_EN
   logic                    timeout_err;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   axi_wr_arb_ctrl #(
      .NUM_M  (NUM_M),
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .ID_W   (ID_W)
`ifdef AXI_WR_ARB_TIMEOUT_EN
      ,
      .TIMEOUT_CYC (16)
`endif
   ) dut (
      .clk (clk), .rst (rst),
      .m_awvalid (m_awvalid), .m_awready (m_awready), .m_awaddr (m_awaddr),
      .m_awid (m_awid), .m_awlen (m_awlen),
      .m_wvalid (m_wvalid), .m_wready (m_wready), .m_wdata (m_wdata), .m_wlast (m_wlast),
      .m_bvalid (m_bvalid), .m_bready (m_bready), .m_bresp (m_bresp), .m_bid (m_bid),
      .s_awvalid (s_awvalid), .s_awready (s_awready), .s_awaddr (s_awaddr),
      .s_awid (s_awid), .s_awlen (s_awlen),
      .s_wvalid (s_wvalid), .s_wready (s_wready), .s_wdata (s_wdata), .s_wlast (s_wlast),
      .s_bvalid (s_bvalid), .s_bready (s_bready), .s_bresp (s_bresp), .s_bid (s_bid),
      .grant_idx (grant_idx),
`ifdef AXI_WR_ARB_TIMEOUT_EN
      .timeout_err (timeout_err),
`endif
      .busy (busy)
   );

   // Count one comparison and report it when observed differs from expected.
   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Wait (bounded) for busy to reach lvl; an expired bound shows up as a failed check.
   task automatic wait_busy(input logic lvl, input string tag);
      int n;
      n = 0;
      #1;
      while (busy !== lvl && n < 20) begin
         cyc();
         #1;
         n++;
      end
      check_eq(tag, busy, lvl);
   endtask

   task automatic clear_inputs();
      m_awvalid = '0; m_wvalid = '0; m_wlast = '0; m_bready = '0;
      s_awready = 1'b0; s_wready = 1'b0; s_bvalid = 1'b0; s_bresp = 2'b00; s_bid = '0;
   endtask

   initial begin
      rst = 1'b1;
      m_awaddr = '0; m_awid = '0; m_awlen = '0; m_wdata = '0;
      clear_inputs();
      cyc(); cyc(); #1;
      // Reset state
      check_eq("rst_busy", busy, 1'b0);
      check_eq("rst_grant", grant_idx, 2'd0);
      check_eq("rst_awready", m_awready, 4'b0000);
      check_eq("rst_wready", m_wready, 4'b0000);
      check_eq("rst_bvalid", m_bvalid, 4'b0000);
      check_eq("rst_s_valids", {s_awvalid, s_wvalid, s_bready}, 3'b000);
      rst = 1'b0;

      // Single request from master 2, AW and WLAST complete in the same cycle
      cyc();
      m_awvalid = 4'b0100; m_awaddr[2*ADDR_W +: ADDR_W] = 32'h1000_0200;
      m_awid[2*ID_W +: ID_W] = 4'h5; m_awlen[2*8 +: 8] = 8'd0;
      m_wvalid = 4'b0100; m_wdata[2*DATA_W +: DATA_W] = 32'hA5A5_0002; m_wlast = 4'b0100;
      s_awready = 1'b1; s_wready = 1'b1;
      #1;
      check_eq("t1_idle_no_aw", s_awvalid, 1'b0);
      cyc(); #1;
      check_eq("t1_grant", grant_idx, 2'd2);
      check_eq("t1_busy", busy, 1'b1);
      check_eq("t1_awvalid", s_awvalid, 1'b1);
      check_eq("t1_awaddr", s_awaddr, 32'h1000_0200);
      check_eq("t1_awid", s_awid, 4'h5);
      check_eq("t1_wvalid", s_wvalid, 1'b1);
      check_eq("t1_wdata", s_wdata, 32'hA5A5_0002);
      check_eq("t1_wlast", s_wlast, 1'b1);
      check_eq("t1_awready", m_awready, 4'b0100);
      check_eq("t1_wready", m_wready, 4'b0100);
      cyc();
      m_awvalid = '0; m_wvalid = '0; m_wlast = '0;
      m_bready = 4'b0100; s_bvalid = 1'b1; s_bresp = 2'b00; s_bid = 4'h5;
      #1;
      check_eq("t1_resp_bready", s_bready, 1'b1);
      check_eq("t1_resp_bvalid", m_bvalid, 4'b0100);
      check_eq("t1_resp_bresp", m_bresp, 2'b00);
      check_eq("t1_resp_bid", m_bid, 4'h5);
      check_eq("t1_resp_awmask", s_awvalid, 1'b0);
      cyc();
      s_bvalid = 1'b0; m_bready = '0;
      #1;
      check_eq("t1_idle_busy", busy, 1'b0);
      check_eq("t1_idle_bvalid", m_bvalid, 4'b0000);

      // W before AW: master 1, 4 beats, s_awready low for 10 cycles
      cyc();
      s_awready = 1'b0; s_wready = 1'b1;
      m_awvalid = 4'b0010; m_awaddr[1*ADDR_W +: ADDR_W] = 32'h2000_0100;
      m_awid[1*ID_W +: ID_W] = 4'h9; m_awlen[1*8 +: 8] = 8'd3;
      m_wvalid = 4'b0010; m_wlast = 4'b0000; m_wdata[1*DATA_W +: DATA_W] = 32'hB000_0000;
      m_bready = 4'b0010;
      cyc(); #1;
      check_eq("t3_grant", grant_idx, 2'd1);
      check_eq("t3_awlen", s_awlen, 8'd3);
      check_eq("t3_awready_low", m_awready, 4'b0000);
      check_eq("t3_wready", m_wready, 4'b0010);
      for (int b = 0; b < 4; b++) begin
         m_wdata[1*DATA_W +: DATA_W] = 32'hB000_0000 + 32'(b);
         m_wlast = (b == 3) ? 4'b0010 : 4'b0000;
         #1;
         check_eq("t3_beat_data", s_wdata, 32'hB000_0000 + 32'(b));
         check_eq("t3_beat_last", s_wlast, (b == 3) ? 1'b1 : 1'b0);
         check_eq("t3_beat_valid", s_wvalid, 1'b1);
         cyc();
      end
      for (int k = 0; k < 6; k++) begin
         #1;
         check_eq("t3_w_masked", s_wvalid, 1'b0);
         check_eq("t3_aw_held", s_awvalid, 1'b1);
         check_eq("t3_no_resp", s_bready, 1'b0);
         cyc();
      end
      s_awready = 1'b1;
      #1;
      check_eq("t3_awready", m_awready, 4'b0010);
      cyc();
      m_awvalid = '0; m_wvalid = '0; m_wlast = '0;
      #1;
      check_eq("t3_resp_bready", s_bready, 1'b1);
      check_eq("t3_resp_nobvalid", m_bvalid, 4'b0000);
      s_bvalid = 1'b1; s_bid = 4'h9; s_bresp = 2'b00;
      #1;
      check_eq("t3_resp_bvalid", m_bvalid, 4'b0010);
      check_eq("t3_resp_bid", m_bid, 4'h9);
      cyc();
      s_bvalid = 1'b0; m_bready = '0;
      #1;
      check_eq("t3_idle_busy", busy, 1'b0);

      // Reset in XFER mid-burst (master 3)
      cyc();
      s_awready = 1'b0; s_wready = 1'b1;
      m_awvalid = 4'b1000; m_awaddr[3*ADDR_W +: ADDR_W] = 32'h3000_0000; m_awlen[3*8 +: 8] = 8'd1;
      m_wvalid = 4'b1000; m_wlast = 4'b0000;
      cyc(); #1;
      check_eq("t5_grant", grant_idx, 2'd3);
      check_eq("t5_wready", m_wready, 4'b1000);
      cyc();
      rst = 1'b1;
      #1;
      check_eq("t5_rst_busy", busy, 1'b0);
      check_eq("t5_rst_grant", grant_idx, 2'd0);
      check_eq("t5_rst_s_valids", {s_awvalid, s_wvalid, s_bready}, 3'b000);
      check_eq("t5_rst_readies", {m_awready, m_wready}, 8'h00);
      clear_inputs();
      cyc();
      rst = 1'b0;

      // All four masters requesting continuously: expect 0,1,2,3,0
      for (int i = 0; i < NUM_M; i++) begin
         m_awaddr[i*ADDR_W +: ADDR_W] = 32'h4000_0000 + 32'(i);
         m_awid[i*ID_W +: ID_W] = ID_W'(i);
         m_awlen[i*8 +: 8] = 8'd0;
         m_wdata[i*DATA_W +: DATA_W] = 32'hC000_0000 + 32'(i);
      end
      m_awvalid = 4'hF; m_wvalid = 4'hF; m_wlast = 4'hF; m_bready = 4'hF;
      s_awready = 1'b1; s_wready = 1'b1; s_bvalid = 1'b1; s_bresp = 2'b00;
      for (int t = 0; t < 5; t++) begin
         wait_busy(1'b1, "rr_wait_grant");
         check_eq("rr_grant", grant_idx, 64'(t % 4));
         check_eq("rr_awid", s_awid, 64'(t % 4));
         wait_busy(1'b0, "rr_wait_idle");
      end
      clear_inputs();

`ifdef AXI_WR_ARB_TIMEOUT_EN
      // Watchdog: slave never answers, error B at RESP cycle 16
      cyc();
      m_awvalid = 4'b0001; m_awid[0 +: ID_W] = 4'hC; m_awlen[0 +: 8] = 8'd0;
      m_wvalid = 4'b0001; m_wlast = 4'b0001;
      s_awready = 1'b1; s_wready = 1'b1; s_bid = 4'h3;
      cyc(); #1;
      check_eq("to_grant", grant_idx, 2'd0);
      cyc();
      m_awvalid = '0; m_wvalid = '0; m_wlast = '0;
      #1;
      check_eq("to_resp0_bvalid", m_bvalid, 4'b0000);
      for (int k = 1; k < 16; k++) begin
         cyc();
      end
      #1;
      check_eq("to_resp15_bvalid", m_bvalid, 4'b0000);
      cyc();
      m_bready = 4'b0001;
      #1;
      check_eq("to_bvalid", m_bvalid, 4'b0001);
      check_eq("to_bresp", m_bresp, 2'b10);
      check_eq("to_bid", m_bid, 4'hC);
      check_eq("to_s_bready", s_bready, 1'b0);
      check_eq("to_err_early", timeout_err, 1'b0);
      cyc(); #1;
      check_eq("to_err_pulse", timeout_err, 1'b1);
      check_eq("to_idle_busy", busy, 1'b0);
      m_bready = '0;
      cyc(); #1;
      check_eq("to_err_clear", timeout_err, 1'b0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
